// File: rtl/gene_net_step_if.sv
// ---------------------------------------------------------------------------
// gene_net_step_if
//
// Purpose:
//   Bundles the control, matrix-write and status signals of the Boolean
//   gene-network stepper so the design and its driver share one port.
//
// Signals (from the point of view of the stepper, i.e. the slave modport):
//   load      in   load init_val as the new network state
//   init_val  in   initial gene state x[0]
//   run       in   level-sensitive stepping enable
//   mat_we    in   interaction-matrix row write strobe
//   mat_addr  in   row (target gene) index
//   mat_act   in   activator mask for that row
//   mat_inh   in   inhibitor mask for that row
//   x         out  current gene state
//   valid     out  one-cycle pulse after every update of x
//   fixed     out  a fixed point has been reached
//   limit     out  the step limit has been reached
//   step_cnt  out  updates since the last load
//
// Modports:
//   master  drives the controls, observes the status (testbench / host)
//   slave   the stepper itself
// ---------------------------------------------------------------------------
interface gene_net_step_if #(
    parameter int NG = 8
);
    localparam int AW = (NG > 1) ? $clog2(NG) : 1;

    logic          load;
    logic [NG-1:0] init_val;
    logic          run;
    logic          mat_we;
    logic [AW-1:0] mat_addr;
    logic [NG-1:0] mat_act;
    logic [NG-1:0] mat_inh;

    logic [NG-1:0] x;
    logic          valid;
    logic          fixed;
    logic          limit;
    logic [7:0]    step_cnt;

    modport master (
        output load, init_val, run, mat_we, mat_addr, mat_act, mat_inh,
        input  x, valid, fixed, limit, step_cnt
    );

    modport slave (
        input  load, init_val, run, mat_we, mat_addr, mat_act, mat_inh,
        output x, valid, fixed, limit, step_cnt
    );
endinterface

// File: rtl/gene_net_step.sv
// ---------------------------------------------------------------------------
// gene_net_step
//
// Purpose:
//   Synchronous Boolean gene-regulatory-network stepper. Every gene i owns an
//   activator row act_i and an inhibitor row inh_i. One step computes
//       score_i = popcount(act_i & x) - popcount(inh_i & x)
//   and the next state bit is 1 only when score_i is strictly positive, so a
//   tie decays to 0. Stepping runs while 'run' is high and stops for good
//   (HALT) when the state stops changing, until the next load.
//
// Parameters:
//   NG        number of genes (8)
//   STEP_MAX  update count at which the optional step limit halts (1..255)
//
// Ports:
//   clk   clock, all state changes on its rising edge
//   rst   asynchronous active-low reset: clears state, flags and the matrix
//   bus   gene_net_step_if.slave (load/run control, matrix write, status)
//
// Build option:
//   GENE_STEP_LIMIT_EN  when defined, step_cnt counts updates and the network
//                       halts with limit=1 once step_cnt reaches STEP_MAX.
//                       When undefined, step_cnt and limit are tied to 0 and
//                       only a fixed point halts the network.
// ---------------------------------------------------------------------------
module gene_net_step #(
    parameter int NG       = 8,
    parameter int STEP_MAX = 255
) (
    input  logic           clk,
    input  logic           rst,
    gene_net_step_if.slave bus
);
    // Popcount width for 0..NG, plus one sign bit for the score difference.
    localparam int CW = $clog2(NG + 1);
    localparam int SW = CW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [NG-1:0] x_q;
    logic [NG-1:0] next_x;
    logic          valid_q;
    logic          fixed_q;
    logic [7:0]    cnt_q;
    logic          limit_q;
    logic          limit_hit;

    logic [NG-1:0] act_q [NG];
    logic [NG-1:0] inh_q [NG];

    logic signed [SW-1:0] score [NG];

    logic do_update;
    logic set_fixed;
    logic mat_wr;

    function automatic logic [CW-1:0] popcount(input logic [NG-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int j = 0; j < NG; j++) begin
            c = c + CW'(v[j]);
        end
        return c;
    endfunction

    // Network update function f(x). Both popcounts are zero-extended before
    // the subtraction so the signed score can never overflow.
    // A gene turns on only for a strictly positive score: sign bit clear and
    // value non-zero.
    always_comb begin : network_fn
        score  = '{default: '0};
        next_x = '0;
        for (int i = 0; i < NG; i++) begin
            score[i]  = $signed({1'b0, popcount(act_q[i] & x_q)})
                      - $signed({1'b0, popcount(inh_q[i] & x_q)});
            next_x[i] = ~score[i][SW-1] & (score[i] != '0);
        end
    end

    // Next-state logic. Load overrides everything and returns to IDLE.
    // The IDLE->RUN edge performs no update; updates start one edge later.
    // A fixed point and the step limit both lead to HALT; when both occur on
    // the same step both flags get set. Matrix rows may be rewritten in any
    // state except RUN, even on an edge that also carries a load.
    always_comb begin : fsm_next
        state_d   = state_q;
        do_update = 1'b0;
        set_fixed = 1'b0;
        mat_wr    = bus.mat_we && (state_q != S_RUN);

        if (bus.load) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.run) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.run) begin
                        do_update = 1'b1;
                        if (next_x == x_q) begin
                            set_fixed = 1'b1;
                            state_d   = S_HALT;
                        end
                        if (limit_hit) begin
                            state_d = S_HALT;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Gene state and the valid/fixed flags. valid simply mirrors whether this
    // edge performed an update, which makes it a one-cycle pulse per update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q     <= '0;
            valid_q <= 1'b0;
            fixed_q <= 1'b0;
        end else if (bus.load) begin
            x_q     <= bus.init_val;
            valid_q <= 1'b0;
            fixed_q <= 1'b0;
        end else begin
            valid_q <= do_update;
            if (do_update) begin
                x_q <= next_x;
            end
            if (set_fixed) begin
                fixed_q <= 1'b1;
            end
        end
    end

    // Interaction matrix. Reset clears every row so a freshly reset network
    // decays to all-zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NG; i++) begin
                act_q[i] <= '0;
                inh_q[i] <= '0;
            end
        end else if (mat_wr) begin
            act_q[bus.mat_addr] <= bus.mat_act;
            inh_q[bus.mat_addr] <= bus.mat_inh;
        end
    end

`ifdef GENE_STEP_LIMIT_EN
    // Saturating update counter; the limit compares against the value the
    // counter will hold after the current update.
    logic [7:0] cnt_inc;

    assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign limit_hit = (cnt_inc == 8'(STEP_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= 8'd0;
            limit_q <= 1'b0;
        end else if (bus.load) begin
            cnt_q   <= 8'd0;
            limit_q <= 1'b0;
        end else if (do_update) begin
            cnt_q <= cnt_inc;
            if (limit_hit) begin
                limit_q <= 1'b1;
            end
        end
    end
`else
    // Without the step limit the counter and flag do not exist; STEP_MAX has
    // no effect and is folded into a deliberately unused net.
    logic unused_step_max;

    assign cnt_q           = 8'd0;
    assign limit_q         = 1'b0;
    assign limit_hit       = 1'b0;
    assign unused_step_max = ^8'(STEP_MAX);
`endif

    assign bus.x        = x_q;
    assign bus.valid    = valid_q;
    assign bus.fixed    = fixed_q;
    assign bus.limit    = limit_q;
    assign bus.step_cnt = cnt_q;

endmodule

// File: tb/tb_gene_net_step.sv
// ---------------------------------------------------------------------------
// tb_gene_net_step
//
// Self-checking bench for gene_net_step. Stimulus tasks drive the interface
// and advance a behavioural model of the network; every update the model
// predicts is queued, and a monitor pops and compares on each valid pulse.
// Direct state snapshots are compared at chosen points as well.
// ---------------------------------------------------------------------------
module tb_gene_net_step;
    localparam int NG          = 8;
    localparam int TB_STEP_MAX = 4;

`ifdef GENE_STEP_LIMIT_EN
    localparam logic [7:0] CNT_MASK  = 8'hFF;
    localparam bit         LIMIT_ON  = 1'b1;
`else
    localparam logic [7:0] CNT_MASK  = 8'h00;
    localparam bit         LIMIT_ON  = 1'b0;
`endif

    typedef enum { M_IDLE, M_RUN, M_HALT } mode_t;

    typedef struct packed {
        logic [7:0] x;
        logic       fixed;
        logic       limit;
        logic [7:0] cnt;
    } resp_t;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    resp_t exp_q[$];

    // Reference model state
    logic [7:0] m_x;
    bit         m_valid;
    bit         m_fixed;
    bit         m_limit;
    int         m_cnt;
    mode_t      m_mode;
    logic [7:0] m_act [NG];
    logic [7:0] m_inh [NG];

    gene_net_step_if #(.NG(NG)) bus ();

    gene_net_step #(
        .NG       (NG),
        .STEP_MAX (TB_STEP_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected sequence completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] cnt_out(input int c);
        return 8'(c) & CNT_MASK;
    endfunction

    // One synchronous step of the network, straight from the rules:
    // a gene is on next time iff it has more active activators than
    // active inhibitors.
    function automatic logic [7:0] model_next(input logic [7:0] cur);
        logic [7:0] nx;
        int         a;
        int         h;
        nx = '0;
        for (int i = 0; i < NG; i++) begin
            a     = $countones(m_act[i] & cur);
            h     = $countones(m_inh[i] & cur);
            nx[i] = (a - h) > 0;
        end
        return nx;
    endfunction

    function automatic void model_reset();
        m_x     = '0;
        m_valid = 1'b0;
        m_fixed = 1'b0;
        m_limit = 1'b0;
        m_cnt   = 0;
        m_mode  = M_IDLE;
        for (int i = 0; i < NG; i++) begin
            m_act[i] = '0;
            m_inh[i] = '0;
        end
    endfunction

    task automatic compareState(input string name);
        logic [7:0] exp_cnt;
        exp_cnt = cnt_out(m_cnt);
        checks++;
        if (bus.x !== m_x || bus.valid !== m_valid || bus.fixed !== m_fixed ||
            bus.limit !== m_limit || bus.step_cnt !== exp_cnt) begin
            failures++;
            $display("[TB] FAIL %s: got x=%02h valid=%b fixed=%b limit=%b step_cnt=%0d, expected x=%02h valid=%b fixed=%b limit=%b step_cnt=%0d",
                     name, bus.x, bus.valid, bus.fixed, bus.limit, bus.step_cnt,
                     m_x, m_valid, m_fixed, m_limit, exp_cnt);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and advance the model to
    // what the next rising edge should produce.
    task automatic applyStimulus(input bit ld, input logic [7:0] iv, input bit rn,
                                 input bit we, input logic [2:0] ad,
                                 input logic [7:0] ac, input logic [7:0] ih);
        logic [7:0] nx;
        bit         wr_ok;
        bit         hit_fix;
        resp_t      r;
        @(negedge clk);
        bus.load     = ld;
        bus.init_val = iv;
        bus.run      = rn;
        bus.mat_we   = we;
        bus.mat_addr = ad;
        bus.mat_act  = ac;
        bus.mat_inh  = ih;

        wr_ok = we && (m_mode != M_RUN);
        if (ld) begin
            m_x     = iv;
            m_mode  = M_IDLE;
            m_fixed = 1'b0;
            m_limit = 1'b0;
            m_cnt   = 0;
            m_valid = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_valid = 1'b0;
                    if (rn) m_mode = M_RUN;
                end
                M_RUN: begin
                    if (rn) begin
                        nx      = model_next(m_x);
                        hit_fix = (nx == m_x);
                        m_x     = nx;
                        if (m_cnt < 255) m_cnt++;
                        m_valid = 1'b1;
                        if (hit_fix) begin
                            m_fixed = 1'b1;
                            m_mode  = M_HALT;
                        end
                        if (LIMIT_ON && m_cnt == TB_STEP_MAX) begin
                            m_limit = 1'b1;
                            m_mode  = M_HALT;
                        end
                        r = '{x: m_x, fixed: m_fixed, limit: m_limit, cnt: cnt_out(m_cnt)};
                        exp_q.push_back(r);
                    end else begin
                        m_mode  = M_IDLE;
                        m_valid = 1'b0;
                    end
                end
                default: begin
                    m_valid = 1'b0;
                end
            endcase
        end
        if (wr_ok) begin
            m_act[ad] = ac;
            m_inh[ad] = ih;
        end
    endtask

    // Compare the state just after the edge that follows the last stimulus
    task automatic checkOutput(input string name);
        @(posedge clk);
        #1;
        compareState(name);
    endtask

    task automatic stepRun(input bit rn);
        applyStimulus(1'b0, 8'h00, rn, 1'b0, 3'd0, 8'h00, 8'h00);
    endtask

    task automatic writeRow(input logic [2:0] ad, input logic [7:0] ac, input logic [7:0] ih);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, ad, ac, ih);
    endtask

    task automatic loadState(input logic [7:0] iv);
        applyStimulus(1'b1, iv, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    endtask

    // Asynchronous reset in the middle of the low clock phase
    task automatic doReset();
        @(negedge clk);
        bus.load   = 1'b0;
        bus.run    = 1'b0;
        bus.mat_we = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compareState("async_reset");
        @(posedge clk);
        #1;
        compareState("reset_held");
        @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    // Scoreboard monitor: each valid pulse must match the oldest predicted update
    always @(negedge clk) begin
        resp_t e;
        resp_t got;
        if (bus.valid === 1'b1) begin
            checks++;
            got = '{x: bus.x, fixed: bus.fixed, limit: bus.limit, cnt: bus.step_cnt};
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_valid: got valid=1 x=%02h, expected no update", bus.x);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("[TB] FAIL scoreboard_update: got x=%02h fixed=%b limit=%b step_cnt=%0d, expected x=%02h fixed=%b limit=%b step_cnt=%0d",
                             got.x, got.fixed, got.limit, got.cnt, e.x, e.fixed, e.limit, e.cnt);
                end
            end
        end
    end

    // Main sequence
    initial begin
        bit         ld;
        bit         rn;
        bit         we;
        logic [2:0] ad;
        logic [7:0] ac;
        logic [7:0] ih;
        logic [7:0] iv;

        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.init_val = 8'h00;
        bus.run      = 1'b0;
        bus.mat_we   = 1'b0;
        bus.mat_addr = 3'd0;
        bus.mat_act  = 8'h00;
        bus.mat_inh  = 8'h00;
        model_reset();
        #1;
        rst = 1'b0;
        #1;
        compareState("reset_state");
        #15;
        rst = 1'b1;

        $display("[TB] identity matrix");
        for (int i = 0; i < 7; i++) begin
            writeRow(3'(i), 8'(1 << i), 8'h00);
        end
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b1, 3'd7, 8'h80, 8'h00);
        stepRun(1'b1);
        checkOutput("idle_to_run");
        stepRun(1'b1);
        checkOutput("identity_fixed");
        repeat (3) stepRun(1'b1);
        checkOutput("halt_hold");

        $display("[TB] zero matrix");
        for (int i = 0; i < NG; i++) begin
            writeRow(3'(i), 8'h00, 8'h00);
        end
        loadState(8'hFF);
        stepRun(1'b1);
        stepRun(1'b1);
        checkOutput("zero_first_update");
        stepRun(1'b1);
        checkOutput("zero_fixed");

        $display("[TB] three-gene ring");
        writeRow(3'd0, 8'h04, 8'h00);
        writeRow(3'd1, 8'h01, 8'h00);
        writeRow(3'd2, 8'h02, 8'h00);
        loadState(8'h01);
        for (int k = 0; k < 11; k++) begin
            stepRun(1'b1);
        end
        checkOutput("ring_run");

        $display("[TB] pause then reset");
        loadState(8'h01);
        stepRun(1'b1);
        stepRun(1'b1);
        stepRun(1'b1);
        stepRun(1'b0);
        checkOutput("pause_hold");
        doReset();
        loadState(8'hFF);
        stepRun(1'b1);
        stepRun(1'b1);
        stepRun(1'b1);
        checkOutput("cleared_matrix");

        $display("[TB] ignored write and load priority");
        writeRow(3'd0, 8'h04, 8'h00);
        writeRow(3'd1, 8'h01, 8'h00);
        writeRow(3'd2, 8'h02, 8'h00);
        loadState(8'h01);
        stepRun(1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 3'd1, 8'h00, 8'hFF);
        stepRun(1'b1);
        stepRun(1'b1);
        stepRun(1'b1);
        checkOutput("ignored_write");
        loadState(8'h01);
        stepRun(1'b1);
        stepRun(1'b1);
        applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00);
        checkOutput("load_in_run");

        $display("[TB] randomized stepping");
        for (int k = 0; k < 400; k++) begin
            ld = ($urandom_range(0, 15) == 0);
            rn = ($urandom_range(0, 9) != 0);
            we = ($urandom_range(0, 3) == 0);
            ad = 3'($urandom_range(0, 7));
            ac = 8'($urandom);
            ih = 8'($urandom & $urandom);
            iv = 8'($urandom);
            applyStimulus(ld, iv, rn, we, ad, ac, ih);
            if (k % 25 == 24) begin
                checkOutput("random_state");
            end
        end

        // Let the monitor consume the last predicted update
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL pending_updates: got %0d unobserved updates, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gene_net_step.md
GENE_NET_STEP -- requirements
Module: gene_net_step

Interface
REQ-001 SHALL have parameter NG, default 8, number of genes; the design is verified only at NG=8.
REQ-002 SHALL have parameter STEP_MAX, default 255, the update count at which the step-limit feature halts; 8-bit range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its posedge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port load, input, 1 bit: loads init_val as the new network state.
REQ-006 SHALL have port init_val, input, 8 bits: initial gene state x[0].
REQ-007 SHALL have port run, input, 1 bit: level-sensitive enable for stepping.
REQ-008 SHALL have port mat_we, input, 1 bit: interaction-matrix row write strobe.
REQ-009 SHALL have port mat_addr, input, 3 bits: target gene row index.
REQ-010 SHALL have port mat_act, input, 8 bits: activator mask for the row; bit j set means gene j activates it.
REQ-011 SHALL have port mat_inh, input, 8 bits: inhibitor mask for the row.
REQ-012 SHALL have port x, output, 8 bits: current gene state; feeds the cycle-detection stage directly.
REQ-013 SHALL have port valid, output, 1 bit: high for one cycle after each update of x.
REQ-014 SHALL have port fixed, output, 1 bit: a fixed point has been reached.
REQ-015 SHALL have port limit, output, 1 bit: the step limit has been reached.
REQ-016 SHALL have port step_cnt, output, 8 bits: number of updates since the last load.

Function
REQ-017 SHALL compute, for each gene i, score_i = popcount(act_i & x) - popcount(inh_i & x), held as 5-bit signed with range -8..+8 and no overflow possible.
REQ-018 SHALL set next x_i = 1 if score_i > 0, else 0; a tie decays to 0.
REQ-019 SHALL implement FSM states IDLE, RUN and HALT.
REQ-020 SHALL give load the highest priority: on the next edge x=init_val, state=IDLE, fixed=0, limit=0, step_cnt=0, valid=0.
REQ-021 SHALL move from IDLE to RUN on an edge with run=1 and load=0, with no update on that edge; first update is on the following edge.
REQ-022 SHALL, in RUN with run=1, latch f(x) into x each edge, set valid=1, and increment step_cnt (saturating at 255).
REQ-023 SHALL, in RUN with run=0, move to IDLE and hold x and step_cnt (pause); valid=0.
REQ-024 SHALL, in RUN when f(x)==x, still perform the update, then set fixed=1 and enter HALT.
REQ-025 SHALL, in HALT, hold all outputs and keep valid=0 until load; run is ignored.
REQ-026 SHALL write rows with mat_we only in IDLE or HALT, taking effect on the next edge; mat_we in RUN is ignored.
REQ-027 SHALL give load priority when load and mat_we are asserted on the same edge; the matrix write still occurs if the state was IDLE or HALT.
REQ-028 SHALL give fixed priority when fixed and limit conditions coincide on the same step; both flags are set and the state goes to HALT.

Reset
REQ-029 SHALL, on rst low, immediately set x=0x00, valid=0, fixed=0, limit=0, step_cnt=0, state=IDLE, and all act/inh rows=0.
REQ-030 SHALL, on rst low mid-RUN, abort the run with no partial update; operation resumes only on the edge after rst is released.

Configuration
REQ-031 SHALL, when GENE_STEP_LIMIT_EN is defined, implement the step-limit feature: after an update makes step_cnt==STEP_MAX, set limit=1 and enter HALT.
REQ-032 SHALL, when GENE_STEP_LIMIT_EN is undefined, tie limit to 0, tie step_cnt to 0, and never halt except at a fixed point; the port list is unchanged.

Verification
REQ-033 SHALL verify the identity matrix: act_i=1<<i, inh=0, load 0xA5, run=1 -> first update x=0xA5, valid=1, fixed=1, then HALT with x held.
REQ-034 SHALL verify the zero matrix: load 0xFF, run -> x=0x00 at update 1; update 2 sees x unchanged -> fixed=1, step_cnt=2.
REQ-035 SHALL verify a 3-ring: act1=0x01, act2=0x02, act0=0x04, load 0x01 -> x=0x02,0x04,0x01,0x02... with fixed never set.
REQ-036 SHALL verify the 3-ring with GENE_STEP_LIMIT_EN and STEP_MAX=4 -> after 4 updates x=0x02, limit=1, HALT; without the macro stepping continues and limit stays 0.
REQ-037 SHALL verify pause and reset mid-run: drop run after 2 ring steps -> x=0x04 held, valid=0; assert rst -> x=0x00 and matrix cleared asynchronously.
REQ-038 SHALL verify ignored writes and load priority: mat_we during RUN -> row unchanged; load during RUN -> next edge x=init_val, IDLE, step_cnt=0.
